// File: rtl/arbiter_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } arb_state_t;

endpackage : arbiter_pkg

// File: rtl/rr_priority_encoder_16.sv
// Combinational round-robin search: first set request at or after ptr, modulo 16.
module rr_priority_encoder_16
    import arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] off;

    // Rotate so that bit 0 of req_rot corresponds to requester ptr.
    assign req_rot = N_REQ'({req, req} >> ptr);

    // NOTE: off gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule : rr_priority_encoder_16

// File: rtl/arbiter_rr_16.sv
// Sixteen-way round-robin arbiter with grant hold, implicit release and timeout.
// Outputs are registered and feed a 4-to-16 decoder (grant_valid -> ena, grant_idx -> in).
module arbiter_rr_16
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] enc_ptr;
    logic             enc_any;
    logic [IDX_W-1:0] enc_idx;
    logic             hold_hit;
    logic             release_hit;

    // While busy the search always starts just past the holder, which is also
    // the pointer value committed on a release.
    assign enc_ptr     = (state_q == S_BUSY) ? idx_q + IDX_W'(1) : ptr_q;
    assign hold_hit    = (cnt_q == HOLD_LAST);
    assign release_hit = done || !req[idx_q] || hold_hit;

    rr_priority_encoder_16 u_enc (
        .req (req),
        .ptr (enc_ptr),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enc_any) begin
                    state_d = S_BUSY;
                    idx_d   = enc_idx;
                    cnt_d   = '0;
                end
            end

            S_BUSY: begin
                if (release_hit) begin
                    timeout_d = hold_hit && !done;
                    ptr_d     = enc_ptr;
                    if (enc_any) begin
                        idx_d = enc_idx;
                        cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid = (state_q == S_BUSY);
    assign grant_idx   = idx_q;
    assign timeout     = timeout_q;

endmodule : arbiter_rr_16

// File: tb/tb_arbiter_rr_16.sv
// Self-checking bench for arbiter_rr_16: directed vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_arbiter_rr_16;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbiter_rr_16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    // Behavioural model: holder, pointer and age (edges elapsed since the grant appeared).
    logic m_valid = 1'b0;
    int   m_idx   = 0;
    int   m_ptr   = 0;
    int   m_age   = 0;
    logic m_to    = 1'b0;

    function automatic int search(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] r, input logic d, input logic rs);
        int  w;
        bit  expired;
        if (rs) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_age = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (!m_valid) begin
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1'b1; m_idx = w; m_age = 0;
            end
        end else begin
            expired = (m_age + 1 >= MAX_HOLD);
            if (d || !r[m_idx] || expired) begin
                m_to  = expired && !d;
                m_ptr = (m_idx + 1) % 16;
                w     = search(r, m_ptr);
                if (w >= 0) begin
                    m_idx = w; m_age = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, advance one rising edge, settle 1 time unit.
    task automatic cycle(input logic [15:0] r, input logic d, input logic rs);
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
    endtask

    typedef struct packed {
        logic [15:0] req;
        logic        done;
        logic        rst;
        logic        v;
        logic [3:0]  idx;
        logic        to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] r, input logic d, input logic rs,
                                input logic v, input logic [3:0] ix, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.rst = rs; x.v = v; x.idx = ix; x.to = t;
        return x;
    endfunction

    initial begin : main
        vec_t        v;
        logic [15:0] r;
        logic        d;
        logic        rs;
        int          found;

        // Reset, then ten idle cycles.
        vecs.push_back(mk(16'h0000, 0, 1, 0, 4'd0, 0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(16'h0000, 0, 0, 0, 4'd0, 0));
        // Two requesters alternate back-to-back on done.
        vecs.push_back(mk(16'h0011, 0, 0, 1, 4'd0, 0));
        vecs.push_back(mk(16'h0011, 1, 0, 1, 4'd4, 0));
        vecs.push_back(mk(16'h0011, 1, 0, 1, 4'd0, 0));
        vecs.push_back(mk(16'h0011, 1, 0, 1, 4'd4, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 4'd4, 0));
        // 0 and 15 from reset: pointer wraps 15 -> 0.
        vecs.push_back(mk(16'h8001, 0, 1, 0, 4'd0, 0));
        vecs.push_back(mk(16'h8001, 0, 0, 1, 4'd0, 0));
        vecs.push_back(mk(16'h8001, 1, 0, 1, 4'd15, 0));
        vecs.push_back(mk(16'h8001, 1, 0, 1, 4'd0, 0));
        vecs.push_back(mk(16'h8001, 1, 0, 1, 4'd15, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 4'd15, 0));
        // Sole requester 2 held to timeout, then re-issued.
        vecs.push_back(mk(16'h0004, 0, 0, 1, 4'd2, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(16'h0004, 0, 0, 1, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 0, 0, 1, 4'd2, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(16'h0004, 0, 0, 1, 4'd2, 0));
        // done coinciding with the hold limit suppresses timeout.
        vecs.push_back(mk(16'h0004, 1, 0, 1, 4'd2, 0));
        // Implicit release hands over to 3, then 3 drops with nobody waiting.
        vecs.push_back(mk(16'h0008, 0, 0, 1, 4'd3, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 4'd3, 0));
        // Pointer sits at 4, so 0 beats 3.
        vecs.push_back(mk(16'h0009, 0, 0, 1, 4'd0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(16'h0009, 0, 0, 1, 4'd0, 0));
        // Drop coinciding with the hold limit still reports timeout.
        vecs.push_back(mk(16'h0008, 0, 0, 1, 4'd3, 1));
        // Reset mid-grant of 7 with everyone requesting.
        vecs.push_back(mk(16'h0080, 0, 1, 0, 4'd0, 0));
        vecs.push_back(mk(16'h0080, 0, 0, 1, 4'd7, 0));
        vecs.push_back(mk(16'hFFFF, 0, 1, 0, 4'd0, 0));
        vecs.push_back(mk(16'hFFFF, 0, 0, 1, 4'd0, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 4'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.req, v.done, v.rst);
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(v.v));
            check($sformatf("vec%0d_idx", i), 32'(grant_idx), 32'(v.idx));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(v.to));
        end

        // Full rotation: every requester in turn, then wrap back to 0.
        cycle(16'h0000, 0, 1);
        cycle(16'hFFFF, 0, 0);
        check("rot_first", 32'(grant_idx), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            cycle(16'hFFFF, 1, 0);
            check($sformatf("rot%0d_valid", k), 32'(grant_valid), 32'd1);
            check($sformatf("rot%0d_idx", k), 32'(grant_idx), 32'(k % 16));
        end

        // Bounded wait for the hold-limit timeout of a lone requester.
        cycle(16'h0000, 0, 1);
        cycle(16'h0020, 0, 0);
        check("hold_grant", 32'(grant_idx), 32'd5);
        found = -1;
        for (int n = 1; n <= 10; n++) begin
            cycle(16'h0020, 0, 0);
            if (timeout === 1'b1) begin
                found = n;
                break;
            end
        end
        check("hold_edges", 32'(found), 32'(MAX_HOLD));
        check("hold_reissue", 32'(grant_idx), 32'd5);
        cycle(16'h0020, 0, 0);
        check("hold_pulse_len", 32'(timeout), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 7))
                0: r = 16'h0000;
                1: r = 16'($urandom);
                2: r = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                3: r = req ^ 16'(1 << $urandom_range(0, 15));
                default: r = req;
            endcase
            d  = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(r, d, rs);
            check("rnd_valid", 32'(grant_valid), 32'(m_valid));
            if (m_valid) check("rnd_idx", 32'(grant_idx), 32'(m_idx));
            check("rnd_timeout", 32'(timeout), 32'(m_to));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_arbiter_rr_16
